// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accept in IDLE, capture the ALU result in EXEC, hold it in RESP until the granted requester acks.
module ula_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_ra,
  input  logic [7:0] req0_rb,
  input  logic [7:0] req1_ra,
  input  logic [7:0] req1_rb,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       resp0_valid,
  output logic       resp1_valid,
  output logic [7:0] resp_data,
  output logic       resp_zero,
  input  logic       resp0_ack,
  input  logic       resp1_ack,
  output logic [7:0] alu_ra,
  output logic [7:0] alu_rb,
  output logic [2:0] alu_opcode,
  input  logic [7:0] alu_result,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       grant_q, grant_d;   // requester owning the operation in flight
  logic       last_q, last_d;     // most recently granted requester
  logic [7:0] ra_q, ra_d;
  logic [7:0] rb_q, rb_d;
  logic [2:0] op_q, op_d;
  logic [7:0] data_q, data_d;
  logic       zero_q, zero_d;
  logic       sel;
  logic       granted_ack;

  // With both requesting, the one not served last goes next.
  always_comb begin
    if (req0_valid && req1_valid) begin
      sel = ~last_q;
    end else begin
      sel = req1_valid;
    end
  end

  assign granted_ack = grant_q ? resp1_ack : resp0_ack;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    ra_d       = ra_q;
    rb_d       = rb_q;
    op_d       = op_q;
    data_d     = data_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          state_d    = EXEC;
          grant_d    = sel;
          last_d     = sel;
          req0_ready = ~sel;
          req1_ready = sel;
          ra_d       = sel ? req1_ra : req0_ra;
          rb_d       = sel ? req1_rb : req0_rb;
          op_d       = sel ? req1_op : req0_op;
        end
      end
      EXEC: begin
        data_d  = alu_result;
        zero_d  = (alu_result == 8'h00);
        state_d = RESP;
      end
      RESP: begin
        if (granted_ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ra_q    <= 8'h00;
      rb_q    <= 8'h00;
      op_q    <= 3'd0;
      data_q  <= 8'h00;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      op_q    <= op_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  assign resp0_valid = (state_q == RESP) && !grant_q;
  assign resp1_valid = (state_q == RESP) && grant_q;
  assign resp_data   = data_q;
  assign resp_zero   = zero_q;
  assign alu_ra      = ra_q;
  assign alu_rb      = rb_q;
  assign alu_opcode  = op_q;
  assign busy        = (state_q != IDLE);

endmodule
